// File: rtl/rc4_pkg.sv
// rc4_pkg: shared RC4 state encoding, array size and key-byte select
package rc4_pkg;

    localparam int S_SIZE             = 256;
    localparam int DEFAULT_KEY_LENGTH = 3;

    typedef enum logic [3:0] {
        IDLE,
        READ_I,
        WAIT_I,
        CALC_J,
        READ_J,
        WAIT_J,
        WRITE_I,
        WRITE_J,
        NEXT,
        DONE
    } state_t;

    // Byte 0 is the most significant byte of a len-byte key.
    function automatic logic [7:0] key_byte(input logic [8*S_SIZE-1:0] key, input int len, input int k);
        return key[8*(len-k)-1 -: 8];
    endfunction

endpackage

// File: rtl/ksa_shuffler.sv
// ksa_shuffler: RC4 key-scheduling permutation of the shared S-RAM
module ksa_shuffler
    import rc4_pkg::*;
#(
    parameter int KEY_LENGTH = DEFAULT_KEY_LENGTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [8*KEY_LENGTH-1:0] secret_key,
    input  logic [7:0]              ram_out,
    output logic [7:0]              address,
    output logic [7:0]              ram_in,
    output logic                    write_enable,
    output logic                    finished
);

    state_t     state, next_state;
    logic [7:0] i, j, si, sj, kidx, kb;
    logic       settle;

    assign kb = key_byte((8*S_SIZE)'(secret_key), KEY_LENGTH, int'(kidx));

    // Datapath registers; NEXT dwells two cycles to give the nine-cycle iteration cadence.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            i      <= '0;
            j      <= '0;
            si     <= '0;
            sj     <= '0;
            kidx   <= '0;
            settle <= 1'b0;
        end else begin
            state <= next_state;
            if (state == WAIT_I) si <= ram_out;
            if (state == CALC_J) j <= j + si + kb;
            if (state == WAIT_J) sj <= ram_out;
            if (state == NEXT) settle <= ~settle;
            if (state == NEXT && settle && i != 8'hFF) begin
                i    <= i + 8'd1;
                kidx <= (kidx == 8'(KEY_LENGTH - 1)) ? '0 : kidx + 8'd1;
            end
            if (state == DONE && !start) begin
                i    <= '0;
                j    <= '0;
                kidx <= '0;
            end
        end
    end

    // Next-state sequencing through read, swap and advance phases.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    next_state = start ? READ_I : IDLE;
            READ_I:  next_state = WAIT_I;
            WAIT_I:  next_state = CALC_J;
            CALC_J:  next_state = READ_J;
            READ_J:  next_state = WAIT_J;
            WAIT_J:  next_state = WRITE_I;
            WRITE_I: next_state = WRITE_J;
            WRITE_J: next_state = NEXT;
            NEXT:    next_state = !settle ? NEXT : (i == 8'hFF ? DONE : READ_I);
            DONE:    next_state = start ? DONE : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // RAM bus decoded from state and registered indices only.
    always_comb begin
        address      = (state == READ_J || state == WRITE_J) ? j : i;
        ram_in       = (state == WRITE_I) ? sj : (state == WRITE_J) ? si : 8'h00;
        write_enable = (state == WRITE_I) || (state == WRITE_J);
        finished     = (state == DONE);
    end

endmodule

// File: tb/tb_ksa_shuffler.sv
// tb_ksa_shuffler: directed checks of the KSA shuffler against a software KSA model
module tb_ksa_shuffler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        preload = 1'b0;
    logic [23:0] secret_key = 24'h0;
    logic [7:0]  ram_out, address, ram_in;
    logic        write_enable, finished;

    logic [7:0]  mem [256];
    logic [7:0]  exp_s [256];
    logic [15:0] wlog [$];
    int          wrun = 0;
    int          bad_pairs = 0;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    ksa_shuffler #(.KEY_LENGTH(3)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .secret_key(secret_key),
        .ram_out(ram_out),
        .address(address),
        .ram_in(ram_in),
        .write_enable(write_enable),
        .finished(finished)
    );

    // Single-port 256x8 RAM, 1-cycle read latency, preloadable to S[i] = i
    always @(posedge clk) begin
        if (preload) begin
            for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
        end else if (write_enable) begin
            mem[address] <= ram_in;
        end
        ram_out <= mem[address];
    end

    // Write monitor: log (addr,data) and count write bursts not exactly two long
    always @(negedge clk) begin
        if (write_enable) begin
            wlog.push_back({address, ram_in});
            wrun <= wrun + 1;
        end else begin
            if (wrun != 0 && wrun != 2) bad_pairs <= bad_pairs + 1;
            wrun <= 0;
        end
    end

    task automatic ksa_ref(input logic [23:0] key, input bit fresh);
        logic [7:0] jj, t, kb;
        if (fresh) for (int k = 0; k < 256; k++) exp_s[k] = 8'(k);
        jj = 8'h00;
        for (int k = 0; k < 256; k++) begin
            kb = key[8*(2 - k % 3) +: 8];
            jj = jj + exp_s[k] + kb;
            t = exp_s[k];
            exp_s[k] = exp_s[jj];
            exp_s[jj] = t;
        end
    endtask

    function automatic int ram_diff();
        int n = 0;
        for (int k = 0; k < 256; k++) if (mem[k] !== exp_s[k]) n++;
        return n;
    endfunction

    task automatic load_ram();
        @(negedge clk);
        preload = 1'b1;
        @(negedge clk);
        preload = 1'b0;
    endtask

    task automatic launch(input logic [23:0] key);
        secret_key = key;
        start = 1'b1;
        @(posedge clk);
    endtask

    task automatic wait_done(output int fc);
        fc = -1;
        for (int c = 1; c <= 3000; c++) begin
            @(negedge clk);
            if (finished) begin
                fc = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (address !== 8'h00) begin errors++; $display("FAIL reset_address: got %h want 00", address); end
        checks++; if (ram_in !== 8'h00) begin errors++; $display("FAIL reset_ram_in: got %h want 00", ram_in); end
        checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", write_enable); end
        checks++; if (finished !== 1'b0) begin errors++; $display("FAIL reset_finished: got %b want 0", finished); end
        reset = 1'b0;
    endtask

    task automatic test_zero_key();
        logic [15:0] tbl [8];
        logic [15:0] got;
        int base, fc;
        tbl = '{16'h0000, 16'h0000, 16'h0101, 16'h0101, 16'h0203, 16'h0302, 16'h0305, 16'h0502};
        load_ram();
        base = wlog.size();
        launch(24'h000000);
        repeat (8) @(negedge clk);
        checks++; if (mem[0] !== 8'h00) begin errors++; $display("FAIL same_index_swap: S[0]=%h want 00", mem[0]); end
        wait_done(fc);
        checks++; if (fc < 0) begin errors++; $display("FAIL zero_key_done: finished never rose"); end
        checks++; if (wlog.size() - base !== 512) begin errors++; $display("FAIL zero_key_writes: got %0d want 512", wlog.size() - base); end
        for (int k = 0; k < 8; k++) begin
            got = (base + k < wlog.size()) ? wlog[base + k] : 16'hxxxx;
            checks++; if (got !== tbl[k]) begin errors++; $display("FAIL zero_key_write%0d: got %h want %h", k, got, tbl[k]); end
        end
        ksa_ref(24'h000000, 1'b1);
        checks++; if (ram_diff() !== 0) begin errors++; $display("FAIL zero_key_ram: %0d bytes differ want 0", ram_diff()); end
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_key_and_hold();
        logic [7:0]  jexp;
        logic [15:0] w0, w1;
        int base, fc;
        load_ram();
        base = wlog.size();
        launch(24'h1A2B3C);
        wait_done(fc);
        checks++; if (fc !== 2305) begin errors++; $display("FAIL finish_cycle: got %0d want 2305", fc); end
        checks++; if (wlog.size() - base !== 512) begin errors++; $display("FAIL key_writes: got %0d want 512", wlog.size() - base); end
        checks++; if (bad_pairs !== 0) begin errors++; $display("FAIL write_pairs: got %0d unpaired bursts want 0", bad_pairs); end
        ksa_ref(24'h1A2B3C, 1'b1);
        checks++; if (ram_diff() !== 0) begin errors++; $display("FAIL key_ram: %0d bytes differ want 0", ram_diff()); end
        base = wlog.size();
        repeat (20) @(negedge clk);
        checks++; if (finished !== 1'b1) begin errors++; $display("FAIL hold_finished: got %b want 1", finished); end
        checks++; if (wlog.size() !== base) begin errors++; $display("FAIL hold_no_rerun: got %0d writes want 0", wlog.size() - base); end
        start = 1'b0;
        @(negedge clk);
        checks++; if (finished !== 1'b0) begin errors++; $display("FAIL drop_finished: got %b want 0", finished); end
        checks++; if (address !== 8'h00) begin errors++; $display("FAIL idle_address: got %h want 00", address); end
        jexp = exp_s[0] + 8'h1A;
        base = wlog.size();
        launch(24'h1A2B3C);
        repeat (8) @(negedge clk);
        w0 = (wlog.size() > base) ? wlog[base] : 16'hxxxx;
        w1 = (wlog.size() > base + 1) ? wlog[base + 1] : 16'hxxxx;
        checks++; if (w0 !== {8'h00, exp_s[jexp]}) begin errors++; $display("FAIL rerun_write0: got %h want %h", w0, {8'h00, exp_s[jexp]}); end
        checks++; if (w1 !== {jexp, exp_s[0]}) begin errors++; $display("FAIL rerun_write1: got %h want %h", w1, {jexp, exp_s[0]}); end
        wait_done(fc);
        ksa_ref(24'h1A2B3C, 1'b0);
        checks++; if (ram_diff() !== 0) begin errors++; $display("FAIL rerun_ram: %0d bytes differ want 0", ram_diff()); end
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_start_pulse();
        int base, fc;
        load_ram();
        launch(24'h0102FF);
        #1 start = 1'b0;
        wait_done(fc);
        checks++; if (fc !== 2305) begin errors++; $display("FAIL pulse_finish_cycle: got %0d want 2305", fc); end
        @(negedge clk);
        checks++; if (finished !== 1'b0) begin errors++; $display("FAIL pulse_one_cycle: got %b want 0", finished); end
        checks++; if (write_enable !== 1'b0 || address !== 8'h00) begin errors++; $display("FAIL pulse_idle: got we=%b addr=%h want we=0 addr=00", write_enable, address); end
        base = wlog.size();
        repeat (5) @(negedge clk);
        checks++; if (wlog.size() !== base) begin errors++; $display("FAIL pulse_stays_idle: got %0d writes want 0", wlog.size() - base); end
        ksa_ref(24'h0102FF, 1'b1);
        checks++; if (ram_diff() !== 0) begin errors++; $display("FAIL pulse_ram: %0d bytes differ want 0", ram_diff()); end
    endtask

    task automatic test_reset_mid();
        int base, fc;
        load_ram();
        base = wlog.size();
        launch(24'hC0FFEE);
        repeat (1000) @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        checks++; if (address !== 8'h00 || write_enable !== 1'b0 || finished !== 1'b0) begin
            errors++; $display("FAIL midreset_idle: got addr=%h we=%b fin=%b want 00/0/0", address, write_enable, finished);
        end
        checks++; if (wlog.size() - base !== 222) begin errors++; $display("FAIL midreset_writes: got %0d want 222", wlog.size() - base); end
        reset = 1'b0;
        load_ram();
        base = wlog.size();
        launch(24'hC0FFEE);
        wait_done(fc);
        checks++; if (fc !== 2305) begin errors++; $display("FAIL midreset_finish_cycle: got %0d want 2305", fc); end
        checks++; if (wlog.size() - base !== 512) begin errors++; $display("FAIL midreset_rerun_writes: got %0d want 512", wlog.size() - base); end
        ksa_ref(24'hC0FFEE, 1'b1);
        checks++; if (ram_diff() !== 0) begin errors++; $display("FAIL midreset_ram: %0d bytes differ want 0", ram_diff()); end
        start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_zero_key();
        test_key_and_hold();
        test_start_pulse();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ksa_shuffler.md
# ksa_shuffler

Second phase of the RC4 datapath: reads the S-array left by the RAM initializer (S[i] = i) and permutes it in place with the RC4 key-scheduling algorithm under a 24-bit secret key. It masters the same single-port 256x8 S-RAM through the same address / ram_in / write_enable bus and the same start/finished handshake. The arbiter hands the bus to this block only after the initializer's finished.

## Interface
Parameters:
- KEY_LENGTH, 3, number of key bytes; key byte k is secret_key[8*(KEY_LENGTH-k)-1 -: 8], so byte 0 is the MSB byte.

Ports:
- clk  in  1  system clock; every register updates on the rising edge.
- reset  in  1  synchronous, active-high; sampled on clk rising edge.
- start  in  1  level request to run one full shuffle.
- secret_key  in  8*KEY_LENGTH  key; must be stable from start high until finished.
- ram_out  in  8  S-RAM read data (q); valid exactly 1 cycle after address is presented.
- address  out  8  S-RAM address.
- ram_in  out  8  S-RAM write data.
- write_enable  out  1  S-RAM write strobe; the RAM writes ram_in at address on the edge where it is high.
- finished  out  1  high while in DONE.

## Operation
- Algorithm: j = 0; for i = 0..255: j = j + S[i] + key[i mod KEY_LENGTH]; swap S[i] and S[j].
- All additions are modulo 256, using 8-bit wrap.
- i mod KEY_LENGTH comes from a wrapping counter (0..KEY_LENGTH-1); no divider.
- FSM states: IDLE, READ_I, WAIT_I, CALC_J, READ_J, WAIT_J, WRITE_I, WRITE_J, NEXT, DONE.
- IDLE: i = j = 0, key index = 0. Go to READ_I when start = 1.
- READ_I: address = i. Next state WAIT_I.
- WAIT_I: capture si = ram_out. Next state CALC_J.
- CALC_J: j <= j + si + key byte. Next state READ_J.
- READ_J: address = j. Next state WAIT_J.
- WAIT_J: capture sj = ram_out. Next state WRITE_I.
- WRITE_I: address = i, ram_in = sj, write_enable = 1. Next state WRITE_J.
- WRITE_J: address = j, ram_in = si, write_enable = 1. Next state NEXT.
- NEXT: if i = 255, go to DONE. Otherwise i++, key index wraps, go to READ_I.
- DONE: finished = 1. Stay while start = 1. Return to IDLE when start = 0.
- The i = 255 test is done before the increment; there is no 9-bit counter.
- Case i = j: both writes target the same address. The second write (si) lands last, so S[i] is unchanged, which is correct.
- start dropped mid-run: ignored; the run completes. DONE then exits on the next cycle, so finished is a 1-cycle pulse.
- Reset mid-run: next state is IDLE, all outputs return to reset values, and the RAM contents are left partially shuffled.

## Timing
- Reset values: address = 0, ram_in = 0, write_enable = 0, finished = 0, state = IDLE.
- All outputs are registered or decoded from the state register only; none depend combinationally on start or ram_out.
- Latency:
  - start sampled high in IDLE at edge 0 → READ_I occupies cycle 1.
  - Each iteration takes 9 cycles (READ_I .. NEXT).
  - finished first goes high in cycle 2305 (256*9 + 1).
- Exactly 512 write_enable cycles per run, always as pairs in consecutive cycles.
- A new run requires start to be seen low in DONE, then high in IDLE.

## Structure
- Shared package rc4_pkg holds:
  - the FSM state enum;
  - S_SIZE = 256;
  - KEY_LENGTH default;
  - the key-byte select function.
- rc4_pkg is shared with ram_initializer and the later PRGA block.
- Single module; no sub-module is needed.
- The bench uses a behavioural 256x8 RAM model with 1-cycle read latency, preloaded with S[i] = i.

## Test plan
- secret_key = 24'h000000: the first 8 writes (addr, data) must be (0,0) (0,0) (1,1) (1,1) (2,3) (3,2) (3,5) (5,2).
- secret_key = 24'h1A2B3C: the final RAM must match the software KSA model byte-for-byte, with 512 writes, and finished must rise at cycle 2305.
- start held high after DONE: finished stays high and no new run begins. Drop start, then raise it: a second run starts with i = j = 0 from IDLE.
- start pulsed for 1 cycle only: the full run still completes, finished pulses for 1 cycle, and the FSM returns to IDLE.
- reset asserted at cycle 1000: the next cycle shows IDLE with address = 0, write_enable = 0, finished = 0. After re-init and a new start, the result matches the reference model.
- Key chosen so that an iteration has i = j (e.g. i = 0 with key byte 0 = 8'h00): S[i] is unchanged after both writes.
